mant_mul_arb: RTL and testbench

MANT_MUL_ARB -- requirements
Module: mant_mul_arb

---
 rtl/fpu_pkg.sv | 17 +
 rtl/mant_mul_core.sv | 46 ++++
 rtl/mant_mul_arb.sv | 148 ++++++++++++++
 tb/tb_mant_mul_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: widths, stage count and port-id type shared by the mantissa multiplier.
package fpu_pkg;
    localparam int MANT_W     = 24;
    localparam int PROD_W     = 48;
    localparam int TAG_W_DFLT = 4;
    localparam int MUL_STAGES = 3;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Port that round-robin priority moves to after p has been served.
    function automatic port_e other_port(input port_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction
endpackage

// File: rtl/mant_mul_core.sv
// mant_mul_core: 24x24 unsigned mantissa multiplier datapath.
// The front half turns a/b into a redundant sum/carry pair.
// The back half resolves a registered sum/carry pair into the final product.
// The caller owns the pipeline registers between the two halves.
module mant_mul_core
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] i_a,
    input  logic [MANT_W-1:0] i_b,
    output logic [PROD_W-1:0] o_sum,
    output logic [PROD_W-1:0] o_carry,
    input  logic [PROD_W-1:0] i_sum,
    input  logic [PROD_W-1:0] i_carry,
    output logic [PROD_W-1:0] o_prod
);
    localparam int PAD_W = PROD_W - MANT_W;

    logic [MANT_W-1:0][PROD_W-1:0] w_pp;
    logic [MANT_W-1:0][PROD_W-1:0] w_rs;
    logic [MANT_W-1:0][PROD_W-1:0] w_rc;

    // One shifted copy of a per set bit of b.
    for (genvar gi = 0; gi < MANT_W; gi++) begin : g_pp
        assign w_pp[gi] = i_b[gi] ? ({{PAD_W{1'b0}}, i_a} << gi) : '0;
    end

    // The first row seeds the redundant accumulator.
    assign w_rs[0] = w_pp[0];
    assign w_rc[0] = '0;

    // Carry-save rows. Each 3:2 row folds in one more partial product.
    // A carry shifted out of bit 47 can be dropped safely.
    // The true product always fits in 48 bits.
    for (genvar gi = 1; gi < MANT_W; gi++) begin : g_csa
        assign w_rs[gi] = w_rs[gi-1] ^ w_rc[gi-1] ^ w_pp[gi];
        assign w_rc[gi] = ((w_rs[gi-1] & w_rc[gi-1]) |
                           (w_rs[gi-1] & w_pp[gi])   |
                           (w_rc[gi-1] & w_pp[gi])) << 1;
    end

    assign o_sum   = w_rs[MANT_W-1];
    assign o_carry = w_rc[MANT_W-1];

    // Final carry-propagate adder.
    assign o_prod  = i_sum + i_carry;
endmodule

// File: rtl/mant_mul_arb.sv
// mant_mul_arb: one mantissa multiplier shared by the FP-mul port (0) and the
// div/sqrt port (1). It uses round-robin arbitration and a 3-stage pipeline.
// Back-pressure comes from the response port owning S3. flush and rst kill
// every product in flight.
module mant_mul_arb
    import fpu_pkg::*;
#(
    parameter int TAG_W = TAG_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [MANT_W-1:0] req0_a,
    input  logic [MANT_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [MANT_W-1:0] req1_a,
    input  logic [MANT_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [PROD_W-1:0] rsp0_prod,
    output logic [TAG_W-1:0]  rsp0_tag,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [PROD_W-1:0] rsp1_prod,
    output logic [TAG_W-1:0]  rsp1_tag
);
    localparam int STAGES = MUL_STAGES;

    // r_vld_pipe[n] is the valid bit of stage Sn.
    logic [STAGES:1]   r_vld_pipe;
    port_e             r_ptr;

    logic [MANT_W-1:0] r_s1_a;
    logic [MANT_W-1:0] r_s1_b;
    port_e             r_s1_port;
    logic [TAG_W-1:0]  r_s1_tag;

    logic [PROD_W-1:0] r_s2_sum;
    logic [PROD_W-1:0] r_s2_carry;
    port_e             r_s2_port;
    logic [TAG_W-1:0]  r_s2_tag;

    logic [PROD_W-1:0] r_s3_prod;
    port_e             r_s3_port;
    logic [TAG_W-1:0]  r_s3_tag;

    logic              w_stall;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc;
    port_e             w_ptr_nxt;
    port_e             w_in_port;
    logic [MANT_W-1:0] w_in_a;
    logic [MANT_W-1:0] w_in_b;
    logic [TAG_W-1:0]  w_in_tag;
    logic [PROD_W-1:0] w_sum;
    logic [PROD_W-1:0] w_carry;
    logic [PROD_W-1:0] w_prod;
    logic              w_rsp_live;

    // Only the consumer of the product sitting in S3 can hold the pipe.
    assign w_stall = r_vld_pipe[STAGES] &&
                     ((r_s3_port == PORT0) ? !rsp0_ready : !rsp1_ready);

    // Grant logic. The pointer port wins a tie, and the pointer moves past the winner.
    // No grant is made while in reset, flushed or stalled.
    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_ptr_nxt = r_ptr;
        if (!rst && !flush && !w_stall) begin
            if (req0_valid && (!req1_valid || r_ptr == PORT0))
                w_gnt0 = 1'b1;
            else if (req1_valid)
                w_gnt1 = 1'b1;
        end
        if (w_gnt0)
            w_ptr_nxt = other_port(PORT0);
        else if (w_gnt1)
            w_ptr_nxt = other_port(PORT1);
    end

    assign w_acc      = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_in_port  = w_gnt1 ? PORT1    : PORT0;
    assign w_in_a     = w_gnt1 ? req1_a   : req0_a;
    assign w_in_b     = w_gnt1 ? req1_b   : req0_b;
    assign w_in_tag   = w_gnt1 ? req1_tag : req0_tag;

    mant_mul_core u_core (
        .i_a     (r_s1_a),
        .i_b     (r_s1_b),
        .o_sum   (w_sum),
        .o_carry (w_carry),
        .i_sum   (r_s2_sum),
        .i_carry (r_s2_carry),
        .o_prod  (w_prod)
    );

    // Priority pointer. Port 0 gets priority after reset, and the pointer moves only on a grant.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= PORT0;
        else
            r_ptr <= w_ptr_nxt;
    end

    // Stage valids. A kill beats a stall, and bubbles advance whenever the pipe is free.
    always_ff @(posedge clk) begin
        if (rst || flush)
            r_vld_pipe <= '0;
        else if (!w_stall)
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
    end

    // Payload registers. These are not reset and are qualified by the valids above.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_s1_a     <= w_in_a;
            r_s1_b     <= w_in_b;
            r_s1_port  <= w_in_port;
            r_s1_tag   <= w_in_tag;
            r_s2_sum   <= w_sum;
            r_s2_carry <= w_carry;
            r_s2_port  <= r_s1_port;
            r_s2_tag   <= r_s1_tag;
            r_s3_prod  <= w_prod;
            r_s3_port  <= r_s2_port;
            r_s3_tag   <= r_s2_tag;
        end
    end

    // A product being killed this cycle is never offered to a consumer.
    assign w_rsp_live = r_vld_pipe[STAGES] && !flush && !rst;
    assign rsp0_valid = w_rsp_live && (r_s3_port == PORT0);
    assign rsp1_valid = w_rsp_live && (r_s3_port == PORT1);
    assign rsp0_prod  = r_s3_prod;
    assign rsp1_prod  = r_s3_prod;
    assign rsp0_tag   = r_s3_tag;
    assign rsp1_tag   = r_s3_tag;
endmodule

// File: tb/tb_mant_mul_arb.sv
// tb_mant_mul_arb: directed scenarios plus a long random run of mant_mul_arb.
module tb_mant_mul_arb;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [23:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [47:0]      rsp0_prod, rsp1_prod;

    typedef struct packed {
        logic [47:0]      prod;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q0[$], q1[$];
    int   gnt_log[$], rsp_log[$], rsp_cyc[$];
    int   tests = 0, fails = 0, cyc = 0;
    bit   mptr = 1'b0;

    always #5 clk = ~clk;

    mant_mul_arb #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_prod(rsp0_prod), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_prod(rsp1_prod), .rsp1_tag(rsp1_tag)
    );

    function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] wa, wb;
        wa = {24'd0, a};
        wb = {24'd0, b};
        return wa * wb;
    endfunction

    function automatic logic [23:0] rnd24();
        case ($urandom_range(0, 7))
            0:       return 24'h000000;
            1:       return 24'hFFFFFF;
            2:       return 24'h800000;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        bit   stall, ok, e0, e1;
        exp_t e;
        cyc++;
        if (rst) begin
            tests++;
            if (req0_ready || req1_ready || rsp0_valid || rsp1_valid) begin
                fails++;
                $display("FAIL reset_outputs: req_ready=%b%b rsp_valid=%b%b want 0000",
                         req1_ready, req0_ready, rsp1_valid, rsp0_valid);
            end
            q0.delete(); q1.delete();
            mptr = 1'b0;
        end else begin
            stall = (rsp0_valid && !rsp0_ready) || (rsp1_valid && !rsp1_ready);
            ok    = !flush && !stall;
            e0    = ok && req0_valid && (!req1_valid || mptr == 1'b0);
            e1    = ok && req1_valid && !e0;
            tests++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                fails++;
                $display("FAIL arb_ready: got r1r0=%b%b want %b%b (v=%b%b ptr=%0d flush=%b stall=%b)",
                         req1_ready, req0_ready, e1, e0, req1_valid, req0_valid, mptr, flush, stall);
            end
            if (flush) begin
                tests++;
                if (rsp0_valid || rsp1_valid) begin
                    fails++;
                    $display("FAIL flush_rsp: rsp_valid=%b%b want 00", rsp1_valid, rsp0_valid);
                end
            end
            if (rsp0_valid) begin
                tests++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL rsp0_spurious: prod=%h tag=%h want no response", rsp0_prod, rsp0_tag);
                end else if (rsp0_prod !== q0[0].prod || rsp0_tag !== q0[0].tag) begin
                    fails++;
                    $display("FAIL rsp0_data: got prod=%h tag=%h want prod=%h tag=%h",
                             rsp0_prod, rsp0_tag, q0[0].prod, q0[0].tag);
                end
                if (rsp0_ready && q0.size() != 0) begin
                    void'(q0.pop_front());
                    rsp_log.push_back(0);
                    rsp_cyc.push_back(cyc);
                end
            end
            if (rsp1_valid) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL rsp1_spurious: prod=%h tag=%h want no response", rsp1_prod, rsp1_tag);
                end else if (rsp1_prod !== q1[0].prod || rsp1_tag !== q1[0].tag) begin
                    fails++;
                    $display("FAIL rsp1_data: got prod=%h tag=%h want prod=%h tag=%h",
                             rsp1_prod, rsp1_tag, q1[0].prod, q1[0].tag);
                end
                if (rsp1_ready && q1.size() != 0) begin
                    void'(q1.pop_front());
                    rsp_log.push_back(1);
                    rsp_cyc.push_back(cyc);
                end
            end
            if (flush) begin
                q0.delete(); q1.delete();
            end
            if (req0_valid && req0_ready) begin
                e.prod = ref_mul(req0_a, req0_b); e.tag = req0_tag;
                q0.push_back(e); gnt_log.push_back(0); mptr = 1'b1;
            end else if (req1_valid && req1_ready) begin
                e.prod = ref_mul(req1_a, req1_b); e.tag = req1_tag;
                q1.push_back(e); gnt_log.push_back(1); mptr = 1'b0;
            end
        end
    end

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; flush = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 0; req0_b = 0; req0_tag = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        repeat (n) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic send(input int p, input logic [23:0] a, input logic [23:0] b, input logic [TAG_W-1:0] t);
        int n = 0;
        if (p == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_tag = t; end
        else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_tag = t; end
        forever begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout: port %0d not accepted in 50 cycles", p);
                break;
            end
        end
        @(posedge clk); #1;
        if (p == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_rsp(input int p, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((p == 0) ? rsp0_valid : rsp1_valid) && n < 20);
        if (!((p == 0) ? rsp0_valid : rsp1_valid)) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: port %0d no response in 20 cycles", p);
        end
    endtask

    task automatic burst(input bit v0, input bit v1, input int count);
        int acc = 0, guard = 0;
        bit a0, a1;
        req0_valid = v0; req0_a = rnd24(); req0_b = rnd24(); req0_tag = TAG_W'($urandom);
        req1_valid = v1; req1_a = rnd24(); req1_b = rnd24(); req1_tag = TAG_W'($urandom);
        while (acc < count && guard < 100) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            guard++;
            if (a0) begin acc++; req0_a = rnd24(); req0_b = rnd24(); req0_tag = TAG_W'($urandom); end
            if (a1) begin acc++; req1_a = rnd24(); req1_b = rnd24(); req1_tag = TAG_W'($urandom); end
        end
        if (acc < count) begin
            tests++; fails++;
            $display("FAIL burst_timeout: %0d of %0d accepted", acc, count);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  n;
        bit  a0, a1;
        idle_inputs();
        req0_valid = 1; req1_valid = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle_inputs();

        // Single full-scale product and its latency
        send(0, 24'hFFFFFF, 24'hFFFFFF, 4'd3);
        wait_rsp(0, n);
        check("t030_latency", n, 3);
        check("t030_prod", rsp0_prod, 48'hFFFFFE000001);
        check("t030_tag", rsp0_tag, 4'd3);
        @(posedge clk); #1;

        // Contention straight after reset alternates 0,1,0,...
        do_reset(2);
        gnt_log.delete(); rsp_log.delete(); rsp_cyc.delete();
        burst(1, 1, 6);
        repeat (8) @(posedge clk); #1;
        check("t031_ngrant", gnt_log.size(), 6);
        check("t031_nrsp", rsp_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < gnt_log.size()) check($sformatf("t031_grant%0d", i), gnt_log[i], i % 2);
            if (i < rsp_log.size()) begin
                check($sformatf("t031_rsp%0d", i), rsp_log[i], i % 2);
                check($sformatf("t031_rspcyc%0d", i), rsp_cyc[i] - rsp_cyc[0], i);
            end
        end

        // Stalled port-1 response stays stable and blocks acceptance
        rsp1_ready = 0;
        send(1, 24'h800000, 24'h800000, 4'd5);
        wait_rsp(1, n);
        for (int i = 0; i < 4; i++) begin
            check("t032_valid", rsp1_valid, 1);
            check("t032_prod", rsp1_prod, 48'h400000000000);
            check("t032_tag", rsp1_tag, 4'd5);
            check("t032_rdy", {req1_ready, req0_ready}, 2'b00);
            @(posedge clk); #1;
            req0_valid = 1; req0_a = 24'h000123; req0_b = 24'h000456; req0_tag = 4'd9;
            if (i < 3) @(negedge clk);
        end
        rsp1_ready = 1;
        @(negedge clk);
        check("t032_hs_valid", rsp1_valid, 1);
        check("t032_acc_on_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        check("t032_after", rsp1_valid, 0);
        repeat (6) @(posedge clk); #1;

        // Flush kills three back-to-back products
        burst(1, 0, 3);
        flush = 1;
        @(negedge clk);
        check("t033_flush_rsp", rsp0_valid, 0);
        @(posedge clk); #1;
        flush = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t033_norsp", rsp0_valid, 0);
        end
        @(posedge clk); #1;
        send(0, 24'h000003, 24'h000005, 4'd7);
        wait_rsp(0, n);
        check("t033_next_lat", n, 3);
        check("t033_next_prod", rsp0_prod, 48'd15);
        @(posedge clk); #1;

        // Reset with products in flight
        do_reset(1);
        rsp0_ready = 0; rsp1_ready = 0;
        burst(1, 1, 3);
        rst = 1;
        @(negedge clk);
        check("t034_rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        @(posedge clk); #1;
        rst = 0; rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk);
        check("t034_post_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        @(posedge clk); #1;
        gnt_log.delete();
        burst(1, 1, 1);
        check("t034_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        repeat (6) @(posedge clk); #1;
        check("t034_drained", q0.size() + q1.size(), 0);

        // Random mixed traffic
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = rnd24(); req0_b = rnd24(); req0_tag = TAG_W'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = rnd24(); req1_b = rnd24(); req1_tag = TAG_W'($urandom);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        idle_inputs();
        repeat (10) @(posedge clk); #1;
        check("t035_q0_empty", q0.size(), 0);
        check("t035_q1_empty", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
